// File: rtl/cls_head.sv
// Classification head: mean-pools the attention output over tokens, applies a linear layer, and reports the logits and the argmax class.
// Optional build macro CLS_TOKEN_EN: use row 0 (the class token) in place of mean pooling.
module cls_head #(
    parameter int MATRIX_SIZE = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 5,
    parameter int ACC_WIDTH   = 20
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic signed [DATA_WIDTH-1:0]        mat_in [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0]        cls_wt [0:NUM_CLASSES*MATRIX_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0]        cls_bs [0:NUM_CLASSES-1],
    output logic signed [ACC_WIDTH-1:0]         logits [0:NUM_CLASSES-1],
    output logic [$clog2(NUM_CLASSES)-1:0]      class_id,
    output logic                                busy,
    output logic                                done
);
    localparam int LOG_M = $clog2(MATRIX_SIZE);
    localparam int CW    = $clog2(NUM_CLASSES);
    localparam int WI    = $clog2(NUM_CLASSES*MATRIX_SIZE);
    localparam int PRW   = 2*DATA_WIDTH;
    localparam logic [LOG_M-1:0] FEAT_LAST = LOG_M'(MATRIX_SIZE-1);
    localparam logic [CW-1:0]    CLS_LAST  = CW'(NUM_CLASSES-1);

    typedef enum logic [2:0] {
        S_IDLE, S_POOL, S_NORM, S_MAC, S_ARGMAX, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [LOG_M-1:0]             feat_cnt;
    logic [CW-1:0]                cls_cnt;
    logic signed [DATA_WIDTH-1:0] pooled [0:MATRIX_SIZE-1];
    logic signed [ACC_WIDTH-1:0]  mac_acc;
    logic signed [ACC_WIDTH-1:0]  logit [0:NUM_CLASSES-1];
    logic signed [ACC_WIDTH-1:0]  best_val;
    logic [CW-1:0]                best_idx;

`ifndef CLS_TOKEN_EN
    localparam int PW = DATA_WIDTH + LOG_M;
    logic signed [DATA_WIDTH-1:0] snapshot [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
    logic signed [PW-1:0]         col_acc [0:MATRIX_SIZE-1];
`endif

    logic [WI-1:0]               wt_idx;
    logic signed [PRW-1:0]       prod;
    logic signed [ACC_WIDTH-1:0] mac_base;
    logic signed [ACC_WIDTH-1:0] mac_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef CLS_TOKEN_EN
                    state_nx = S_MAC;
`else
                    state_nx = S_POOL;
`endif
                end
            end
            S_POOL:   if (feat_cnt == FEAT_LAST) state_nx = S_NORM;
            S_NORM:   state_nx = S_MAC;
            S_MAC:    if (feat_cnt == FEAT_LAST && cls_cnt == CLS_LAST) state_nx = S_ARGMAX;
            S_ARGMAX: if (cls_cnt == CLS_LAST) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // done is registered one edge after DONE, so busy must also cover that pulse cycle
    assign busy = (state != S_IDLE) || done;

    always_comb begin
        wt_idx   = WI'(cls_cnt) * WI'(MATRIX_SIZE) + WI'(feat_cnt);
        prod     = PRW'(pooled[feat_cnt]) * PRW'(cls_wt[wt_idx]);
        mac_base = (feat_cnt == '0) ? ACC_WIDTH'(cls_bs[cls_cnt]) : mac_acc;
        mac_sum  = mac_base + ACC_WIDTH'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_cnt <= '0;
            cls_cnt  <= '0;
            mac_acc  <= '0;
            best_val <= '0;
            best_idx <= '0;
            class_id <= '0;
            done     <= 1'b0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                logit[c]  <= '0;
                logits[c] <= '0;
            end
            for (int unsigned j = 0; j < MATRIX_SIZE; j++) begin
                pooled[j] <= '0;
`ifndef CLS_TOKEN_EN
                col_acc[j] <= '0;
                for (int unsigned r = 0; r < MATRIX_SIZE; r++) snapshot[r][j] <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        feat_cnt <= '0;
                        cls_cnt  <= '0;
                        for (int unsigned j = 0; j < MATRIX_SIZE; j++) begin
`ifdef CLS_TOKEN_EN
                            pooled[j] <= mat_in[0][j];
`else
                            col_acc[j] <= '0;
                            for (int unsigned r = 0; r < MATRIX_SIZE; r++) snapshot[r][j] <= mat_in[r][j];
`endif
                        end
                    end
                end
`ifndef CLS_TOKEN_EN
                S_POOL: begin
                    for (int unsigned j = 0; j < MATRIX_SIZE; j++)
                        col_acc[j] <= col_acc[j] + PW'(snapshot[feat_cnt][j]);
                    feat_cnt <= (feat_cnt == FEAT_LAST) ? '0 : feat_cnt + 1'b1;
                end
                S_NORM: begin
                    // arithmetic shift floors toward -inf; the mean of DATA_WIDTH values always fits
                    for (int unsigned j = 0; j < MATRIX_SIZE; j++)
                        pooled[j] <= DATA_WIDTH'(col_acc[j] >>> LOG_M);
                end
`endif
                S_MAC: begin
                    mac_acc <= mac_sum;
                    if (feat_cnt == FEAT_LAST) begin
                        logit[cls_cnt] <= mac_sum;
                        feat_cnt       <= '0;
                        cls_cnt        <= (cls_cnt == CLS_LAST) ? '0 : cls_cnt + 1'b1;
                    end else begin
                        feat_cnt <= feat_cnt + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    if (cls_cnt == '0 || logit[cls_cnt] > best_val) begin
                        best_val <= logit[cls_cnt];
                        best_idx <= cls_cnt;
                    end
                    cls_cnt <= (cls_cnt == CLS_LAST) ? '0 : cls_cnt + 1'b1;
                end
                S_DONE: begin
                    for (int unsigned c = 0; c < NUM_CLASSES; c++) logits[c] <= logit[c];
                    class_id <= best_idx;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cls_head.sv
// Directed bench for cls_head (default mean-pooling build): vector table plus reset and handshake sequences.
module tb_cls_head;
    localparam int M   = 16;
    localparam int DW  = 8;
    localparam int NC  = 5;
    localparam int AW  = 20;
    localparam int LAT = 103;

    logic clk;
    logic rst_n;
    logic start;
    logic signed [DW-1:0] mat_in [0:M-1][0:M-1];
    logic signed [DW-1:0] cls_wt [0:NC*M-1];
    logic signed [DW-1:0] cls_bs [0:NC-1];
    logic signed [AW-1:0] logits [0:NC-1];
    logic [2:0]           class_id;
    logic                 busy;
    logic                 done;

    cls_head #(.MATRIX_SIZE(M), .DATA_WIDTH(DW), .NUM_CLASSES(NC), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mat_in(mat_in), .cls_wt(cls_wt),
        .cls_bs(cls_bs), .logits(logits), .class_id(class_id), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // mode 0: every weight = wval; 1: class wcls row = wval, rest 0; 2: only cls_wt[0] = wval
    typedef struct packed {
        int mat_all;
        int m00_en;
        int m00;
        int mode;
        int wcls;
        int wval;
        logic [NC-1:0][31:0] bs;
        logic [NC-1:0][31:0] ex;
        int cls;
    } vec_t;

    vec_t vecs [0:5];

    function automatic vec_t mk(int ma, int m00en, int m00, int mode, int wc, int wv,
                                int b0, int b1, int b2, int b3, int b4,
                                int x0, int x1, int x2, int x3, int x4, int cls);
        vec_t v;
        v.mat_all = ma; v.m00_en = m00en; v.m00 = m00;
        v.mode = mode; v.wcls = wc; v.wval = wv;
        v.bs[0] = b0; v.bs[1] = b1; v.bs[2] = b2; v.bs[3] = b3; v.bs[4] = b4;
        v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2; v.ex[3] = x3; v.ex[4] = x4;
        v.cls = cls;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_vec(input int k);
        vec_t v;
        int w;
        v = vecs[k];
        for (int r = 0; r < M; r++)
            for (int j = 0; j < M; j++) mat_in[r][j] = DW'(v.mat_all);
        if (v.m00_en != 0) mat_in[0][0] = DW'(v.m00);
        for (int i = 0; i < NC*M; i++) begin
            case (v.mode)
                0:       w = v.wval;
                1:       w = (i / M == v.wcls) ? v.wval : 0;
                default: w = (i == 0) ? v.wval : 0;
            endcase
            cls_wt[i] = DW'(w);
        end
        for (int c = 0; c < NC; c++) cls_bs[c] = DW'($signed(v.bs[c]));
    endtask

    task automatic pulse_start(output int e0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int e0, input bit idle_after);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", found, 1);
        if (found) begin
            check("done_latency", cyc - e0, LAT);
            check("busy_in_done", busy, 1);
            if (idle_after) begin
                @(negedge clk);
                check("done_single", done, 0);
                check("busy_fall", busy, 0);
            end
        end
    endtask

    task automatic check_outputs(input int k);
        for (int c = 0; c < NC; c++)
            check($sformatf("vec%0d_logit%0d", k, c), logits[c], $signed(vecs[k].ex[c]));
        check($sformatf("vec%0d_class_id", k), class_id, vecs[k].cls);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        vecs[0] = mk(3, 0, 0, 1, 2, 1,      0, 0, 0, 0, 0,   0, 0, 48, 0, 0, 2);
        vecs[1] = mk(0, 1, -1, 2, 0, 10,    0, 0, 0, 0, 0,   -10, 0, 0, 0, 0, 1);
        vecs[2] = mk(3, 0, 0, 0, 0, 0,      5, 7, 7, 1, 0,   5, 7, 7, 1, 0, 1);
        vecs[3] = mk(-128, 0, 0, 0, 0, -128, 127, 127, 127, 127, 127,
                     262271, 262271, 262271, 262271, 262271, 0);
        vecs[4] = mk(1, 1, -20, 0, 0, 1,    0, 0, 0, 0, 0,   14, 14, 14, 14, 14, 0);
        vecs[5] = mk(2, 0, 0, 1, 4, -1,     0, 0, 0, 0, 3,   0, 0, 0, 0, -29, 0);

        rst_n = 1'b0;
        start = 1'b0;
        load_vec(0);
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_class_id", class_id, 0);
        for (int c = 0; c < NC; c++) check($sformatf("reset_logit%0d", c), logits[c], 0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            load_vec(k);
            pulse_start(e0);
            check("busy_after_start", busy, 1);
            wait_done(e0, 1'b1);
            check_outputs(k);
        end

        // reset mid-MAC after a nonzero result is latched
        load_vec(3);
        pulse_start(e0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_class_id", class_id, 0);
        for (int c = 0; c < NC; c++) check($sformatf("midrst_logit%0d", c), logits[c], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_vec(0);
        pulse_start(e0);
        wait_done(e0, 1'b1);
        check_outputs(0);

        // start while busy, with a different matrix, must be ignored
        load_vec(0);
        pulse_start(e0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < M; r++)
            for (int j = 0; j < M; j++) mat_in[r][j] = 8'sd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_during_ignored_start", busy, 1);
        wait_done(e0, 1'b0);
        check_outputs(0);

        // back-to-back: start sampled on the edge that ends done
        load_vec(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e1 = cyc;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done(e1, 1'b1);
        check_outputs(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
